// File: rtl/counter_ui_pkg.sv
// Shared constants for the counter front-end: default timing values, channel
// indices and a counter-width helper.
package counter_ui_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int REPEAT_DELAY_DEF    = 500000;
    localparam int REPEAT_PERIOD_DEF   = 100000;

    localparam int CH_UP   = 0;
    localparam int CH_DOWN = 1;

    // Bits needed to hold values 0..n-1; never returns less than 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter and, when
// BTN_AUTOREPEAT_EN is defined, a repeat counter for held-press pulses.
module btn_debounce_ch
    import counter_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int DCNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic              s1;
    logic              s2;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nxt;
    logic              level_nxt;
    logic              press_nxt;
    logic              release_nxt;
    logic              accept;

`ifdef BTN_AUTOREPEAT_EN
    // rcnt wraps from DELAY+PERIOD back to DELAY, so it stays bounded.
    localparam int RCNT_W = cnt_width(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RCNT_W-1:0] RCNT_FIRST = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RCNT_WRAP  = RCNT_W'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_nxt;
    logic [RCNT_W-1:0] rcnt_inc;
`endif

    always_comb begin
        // NOTE: every variable driven here gets a default first, otherwise a
        // path that skips an assignment infers a latch.
        dcnt_nxt    = '0;
        level_nxt   = level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        accept      = 1'b0;

        if (ena && (s2 != level)) begin
            if (dcnt == DCNT_LAST) begin
                accept      = 1'b1;
                level_nxt   = s2;
                press_nxt   = s2;
                release_nxt = ~s2;
            end else begin
                dcnt_nxt = dcnt + DCNT_W'(1);
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        rcnt_nxt = '0;
        rcnt_inc = rcnt + RCNT_W'(1);
        // An accepted edge (either direction) restarts the repeat count.
        if (ena && level && !accept) begin
            if (rcnt_inc == RCNT_WRAP) begin
                rcnt_nxt  = RCNT_FIRST;
                press_nxt = 1'b1;
            end else begin
                rcnt_nxt  = rcnt_inc;
                press_nxt = (rcnt_inc == RCNT_FIRST);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            dcnt          <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt          <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so s2 takes the old s1, giving a
            // true two-stage synchroniser regardless of statement order.
            s1            <= raw;
            s2            <= s1;
            dcnt          <= dcnt_nxt;
            level         <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
`ifdef BTN_AUTOREPEAT_EN
            rcnt          <= rcnt_nxt;
`endif
        end
    end

endmodule

// File: rtl/counter_btn_debounce.sv
// N-channel push-button conditioner feeding the counter core (ch0 up, ch1 down).
// Optional held-button autorepeat is built when BTN_AUTOREPEAT_EN is defined.
module counter_btn_debounce
    import counter_ui_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .ena           (ena),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

endmodule

// File: tb/tb_counter_btn_debounce.sv
// Randomised and directed bench for counter_btn_debounce, checked against a
// streak-counting reference model (autorepeat modelled when BTN_AUTOREPEAT_EN).
module tb_counter_btn_debounce;

    localparam int NCH = 2;
    localparam int DC  = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ena = 1'b1;
    logic [NCH-1:0] btn_raw = '0;
    logic [NCH-1:0] btn_level;
    logic [NCH-1:0] btn_press;
    logic [NCH-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    counter_btn_debounce #(
        .N_CH            (NCH),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    // Reference model: raw delayed two clocks, then a new level is accepted
    // after DC consecutive enabled cycles of disagreement.
    bit             m_d1   [NCH];
    bit             m_d2   [NCH];
    int             m_run  [NCH];
    int             m_held [NCH];
    logic [NCH-1:0] exp_level;
    logic [NCH-1:0] exp_press;
    logic [NCH-1:0] exp_release;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_run[c] = 0; m_held[c] = 0;
        end
        exp_level = '0; exp_press = '0; exp_release = '0;
    endtask

    task automatic model_clock();
        bit accepted;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            accepted       = 1'b0;
            exp_press[c]   = 1'b0;
            exp_release[c] = 1'b0;
            if (ena && (m_d2[c] != exp_level[c])) begin
                m_run[c]++;
                if (m_run[c] == DC) begin
                    accepted       = 1'b1;
                    m_run[c]       = 0;
                    exp_level[c]   = m_d2[c];
                    exp_press[c]   = m_d2[c];
                    exp_release[c] = !m_d2[c];
                end
            end else begin
                m_run[c] = 0;
            end
`ifdef BTN_AUTOREPEAT_EN
            if (accepted || !ena || !exp_level[c]) begin
                m_held[c] = 0;
            end else begin
                m_held[c]++;
                if (m_held[c] >= RD && ((m_held[c] - RD) % RP) == 0)
                    exp_press[c] = 1'b1;
            end
`endif
            m_d2[c] = m_d1[c];
            m_d1[c] = btn_raw[c];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check("level",   32'(btn_level),   32'(exp_level));
        check("press",   32'(btn_press),   32'(exp_press));
        check("release", 32'(btn_release), 32'(exp_release));
        check("excl",    32'(btn_press & btn_release), 32'h0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset_pulse(input int hold);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_now", 32'({btn_level, btn_press, btn_release}), 32'h0);
        steps(hold);
        rst = 1'b0;
    endtask

    // Counts steps until btn_press matches mask; returns -1 after a bound.
    task automatic wait_press(input logic [NCH-1:0] mask, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if ((btn_press & mask) == mask) begin
                n = i;
                break;
            end
        end
    endtask

    int lat;
    int pulses;

    initial begin
        model_reset();

        // Reset held with both buttons pressed.
        btn_raw = 2'b11;
        steps(3);
        check("rst_outs", 32'({btn_level, btn_press, btn_release}), 32'h0);
        rst = 1'b0;
        wait_press(2'b11, 20, lat);
        check("rst_lat", 32'(lat), 32'(DC + 2));
        steps(4);

        // Release both, then a clean press on ch0.
        btn_raw = 2'b00;
        steps(10);
        btn_raw = 2'b01;
        wait_press(2'b01, 20, lat);
        check("press_lat", 32'(lat), 32'(DC + 2));
        steps(6);

        // Release ch0, then bounce it.
        btn_raw = 2'b00;
        steps(10);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            btn_raw[0] = (i < 6) ? ~i[0] : 1'b0;
            step();
            pulses += int'(btn_press[0]) + int'(btn_release[0]);
        end
        check("bounce_pulses", 32'(pulses), 32'h0);
        check("bounce_level",  32'(btn_level[0]), 32'h0);

        // Reset in the middle of a press count, button still held afterwards.
        btn_raw = 2'b01;
        steps(4);
        async_reset_pulse(2);
        wait_press(2'b01, 20, lat);
        check("rearm_lat", 32'(lat), 32'(DC + 2));
        steps(4);

        // Enable gating on ch1.
        ena = 1'b0;
        btn_raw[1] = 1'b1;
        steps(10);
        check("gated_level", 32'(btn_level[1]), 32'h0);
        ena = 1'b1;
        steps(10);
        check("ungated_level", 32'(btn_level[1]), 32'h1);

`ifdef BTN_AUTOREPEAT_EN
        btn_raw = 2'b00;
        steps(12);
        btn_raw = 2'b01;
        wait_press(2'b01, 20, lat);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            pulses += int'(btn_press[0]);
        end
        check("repeat_count", 32'(pulses), 32'd6);
        btn_raw = 2'b00;
        steps(20);
`endif

        // Randomised phase: sparse level changes, bounce bursts, enable and
        // reset activity.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 15) == 0) btn_raw[c] = ~btn_raw[c];
            if ($urandom_range(0, 150) == 0) ena = ~ena;
            if (!ena && $urandom_range(0, 20) == 0) ena = 1'b1;
            if ($urandom_range(0, 700) == 0) async_reset_pulse($urandom_range(1, 3));
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
